// File: rtl/intr_ctrl_if.sv
// Interrupt controller <-> core bundle.
// Optional macro: INTR_MASK_EN adds irq_mask (1 = source enabled).
// Signals:
//   irq_in      raw request lines (rising-edge sensitive)
//   irq_ack     core accepts the pending redirect this cycle
//   pc_next     return address captured on ack
//   mret        mret instruction retiring (one-cycle pulse)
//   irq_req     registered redirect request
//   irq_vec     redirect target, stable while irq_req=1
//   epc_out     top of the EPC stack, 0 when empty
//   pending     latched pending bits
//   in_service  sources currently being serviced
//   depth       nesting depth
//   ret_err     sticky: mret seen with nothing in service
// Modports: master = core side, slave = controller side.
interface intr_ctrl_if #(
  parameter int unsigned NSRC   = 3,
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned DEPTH_W = $clog2(NSRC + 1);

  logic [NSRC-1:0]    irq_in;
  logic               irq_ack;
  logic [ADDR_W-1:0]  pc_next;
  logic               mret;
`ifdef INTR_MASK_EN
  logic [NSRC-1:0]    irq_mask;
`endif
  logic               irq_req;
  logic [ADDR_W-1:0]  irq_vec;
  logic [ADDR_W-1:0]  epc_out;
  logic [NSRC-1:0]    pending;
  logic [NSRC-1:0]    in_service;
  logic [DEPTH_W-1:0] depth;
  logic               ret_err;

  modport master (
    output irq_in, irq_ack, pc_next, mret,
    input  irq_req, irq_vec, epc_out, pending, in_service, depth, ret_err
`ifdef INTR_MASK_EN
    , output irq_mask
`endif
  );

  modport slave (
    input  irq_in, irq_ack, pc_next, mret,
    output irq_req, irq_vec, epc_out, pending, in_service, depth, ret_err
`ifdef INTR_MASK_EN
    , input irq_mask
`endif
  );
endinterface

// File: rtl/intr_ctrl.sv
// Vectored, nesting interrupt controller for the single-cycle RV32 core.
// Optional macro: INTR_MASK_EN (per-source enable via bus.irq_mask; when
// undefined every source is enabled).
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  intr_ctrl_if.slave (request lines, ack/mret handshake, status)
// Rising edges on irq_in latch pending bits. In IDLE the highest pending
// source strictly above the current in-service priority is requested with
// its vector; the request is held until the core acks, at which point the
// return PC is pushed and the source enters service. mret pops the stack and
// retires the highest in-service source.
module intr_ctrl #(
  parameter int unsigned        NSRC       = 3,
  parameter int unsigned        ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  VEC_BASE   = ADDR_W'(32'h0000_0100),
  parameter int unsigned        VEC_STRIDE = 4
) (
  input  logic       clk,
  input  logic       rst,
  intr_ctrl_if.slave bus
);
  localparam int unsigned DEPTH_W = $clog2(NSRC + 1);
  localparam int unsigned IDX_W   = (NSRC > 1) ? $clog2(NSRC) : 1;
  // Sized to the full depth index range so the stack index width matches;
  // only the first NSRC entries can ever be written.
  localparam int unsigned STACK_N = 1 << DEPTH_W;

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t             state;
  logic [NSRC-1:0]    irq_d;
  logic [NSRC-1:0]    pending_q;
  logic [NSRC-1:0]    in_service_q;
  logic [NSRC-1:0]    enable;
  logic [NSRC-1:0]    edge_det;
  logic [NSRC-1:0]    req_onehot;
  logic [NSRC-1:0]    cp_onehot;
  logic [IDX_W-1:0]   req_idx;
  logic [IDX_W-1:0]   cp_idx;
  logic [IDX_W-1:0]   cand_idx;
  logic               cp_valid;
  logic               cand_valid;
  logic [DEPTH_W-1:0] depth_q;
  logic               irq_req_q;
  logic               ret_err_q;
  logic [ADDR_W-1:0]  irq_vec_q;
  logic [ADDR_W-1:0]  stack [STACK_N];
  logic               ack_take;
  logic               mret_ok;

`ifdef INTR_MASK_EN
  assign enable = bus.irq_mask;
`else
  assign enable = '1;
`endif

  assign edge_det   = bus.irq_in & ~irq_d;
  // mret wins over a simultaneous ack; the request stays up.
  assign ack_take   = (state == S_REQ) && bus.irq_ack && !bus.mret;
  assign mret_ok    = bus.mret && (depth_q != '0);
  assign req_onehot = NSRC'(1) << req_idx;
  assign cp_onehot  = NSRC'(1) << cp_idx;

  // Current priority and candidate selection (higher index wins).
  always_comb begin
    cp_valid   = 1'b0;
    cp_idx     = '0;
    cand_valid = 1'b0;
    cand_idx   = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (in_service_q[i]) begin
        cp_valid = 1'b1;
        cp_idx   = IDX_W'(i);
      end
    end
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (pending_q[i] && enable[i] && (!cp_valid || (IDX_W'(i) > cp_idx))) begin
        cand_valid = 1'b1;
        cand_idx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      irq_req_q    <= 1'b0;
      irq_vec_q    <= '0;
      req_idx      <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      depth_q      <= '0;
      ret_err_q    <= 1'b0;
      irq_d        <= bus.irq_in;
    end else begin
      irq_d     <= bus.irq_in;
      // A new edge in the clearing cycle keeps the bit set.
      pending_q <= (pending_q & ~(ack_take ? req_onehot : '0)) | edge_det;

      if (bus.mret && (depth_q == '0))
        ret_err_q <= 1'b1;

      if (ack_take) begin
        in_service_q <= in_service_q | req_onehot;
        depth_q      <= depth_q + DEPTH_W'(1);
      end else if (mret_ok) begin
        in_service_q <= in_service_q & ~cp_onehot;
        depth_q      <= depth_q - DEPTH_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (cand_valid) begin
            irq_req_q <= 1'b1;
            irq_vec_q <= VEC_BASE + (ADDR_W'(cand_idx) * ADDR_W'(VEC_STRIDE));
            req_idx   <= cand_idx;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (ack_take) begin
            irq_req_q <= 1'b0;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Return-PC stack: contents need no reset, depth qualifies them.
  always_ff @(posedge clk) begin
    if (ack_take)
      stack[depth_q] <= bus.pc_next;
  end

  assign bus.irq_req    = irq_req_q;
  assign bus.irq_vec    = irq_vec_q;
  assign bus.epc_out    = (depth_q == '0) ? '0 : stack[depth_q - DEPTH_W'(1)];
  assign bus.pending    = pending_q;
  assign bus.in_service = in_service_q;
  assign bus.depth      = depth_q;
  assign bus.ret_err    = ret_err_q;
endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: stimulus pushes the expected vector and
// arrival cycle of every request; a monitor pops and compares on each
// rising irq_req. Status outputs are checked directly after each step.
module tb_intr_ctrl;
  localparam int unsigned NSRC   = 3;
  localparam int unsigned ADDR_W = 32;

  typedef struct {
    logic [31:0] vec;
    int unsigned at;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        prev_req = 1'b0;
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;
  exp_t        sb_q[$];

  intr_ctrl_if #(.NSRC(NSRC), .ADDR_W(ADDR_W)) bus ();

  intr_ctrl #(
    .NSRC(NSRC),
    .ADDR_W(ADDR_W),
    .VEC_BASE(32'h0000_0100),
    .VEC_STRIDE(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] vec, input int unsigned lat);
    exp_t e;
    e.vec = vec;
    e.at  = cyc + lat;
    sb_q.push_back(e);
  endtask

  // Monitor: every rising irq_req must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.irq_req === 1'b1 && prev_req !== 1'b1) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_req: got vec 0x%0h at cycle %0d, expected no request",
                   bus.irq_vec, cyc);
        end else begin
          e = sb_q.pop_front();
          check("req_vec", bus.irq_vec, e.vec);
          check("req_cycle", cyc, e.at);
        end
      end
      prev_req = bus.irq_req;
    end
  end

  // All stimulus tasks start and end just after a negedge.
  task automatic pulse(input logic [NSRC-1:0] bits);
    bus.irq_in = bus.irq_in | bits;
    @(negedge clk);
    bus.irq_in = bus.irq_in & ~bits;
  endtask

  task automatic ack(input logic [31:0] pc);
    bus.irq_ack = 1'b1;
    bus.pc_next = pc;
    @(negedge clk);
    bus.irq_ack = 1'b0;
  endtask

  task automatic do_mret();
    bus.mret = 1'b1;
    @(negedge clk);
    bus.mret = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (bus.irq_req !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (bus.irq_req !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL req_timeout: got irq_req=%b, expected 1 within 8 cycles", bus.irq_req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.irq_in  = 3'b010;   // line already high during reset must not fire
    bus.irq_ack = 1'b0;
    bus.mret    = 1'b0;
    bus.pc_next = '0;
`ifdef INTR_MASK_EN
    bus.irq_mask = '1;
`endif
    rst = 1'b1;
    tick(2);
    rst = 1'b0;

    check("rst_req",   32'(bus.irq_req), 32'h0);
    check("rst_vec",   bus.irq_vec, 32'h0);
    check("rst_pend",  32'(bus.pending), 32'h0);
    check("rst_isv",   32'(bus.in_service), 32'h0);
    check("rst_depth", 32'(bus.depth), 32'h0);
    check("rst_err",   32'(bus.ret_err), 32'h0);
    check("rst_epc",   bus.epc_out, 32'h0);
    tick(3);
    check("held_line_no_edge", 32'(bus.pending), 32'h0);

    // Single source
    push_exp(32'h100, 2);
    pulse(3'b001);
    wait_req();
    check("s1_pend", 32'(bus.pending), 32'h1);
    ack(32'h40);
    check("s1_depth", 32'(bus.depth), 32'h1);
    check("s1_isv",   32'(bus.in_service), 32'h1);
    check("s1_epc",   bus.epc_out, 32'h40);
    check("s1_req",   32'(bus.irq_req), 32'h0);
    check("s1_pclr",  32'(bus.pending), 32'h0);
    bus.irq_in = 3'b000;
    do_mret();
    check("s1_m_depth", 32'(bus.depth), 32'h0);
    check("s1_m_epc",   bus.epc_out, 32'h0);
    check("s1_m_isv",   32'(bus.in_service), 32'h0);

    // Nesting
    push_exp(32'h100, 2);
    pulse(3'b001);
    wait_req();
    ack(32'h40);
    push_exp(32'h108, 2);
    pulse(3'b100);
    wait_req();
    ack(32'h80);
    check("n_depth", 32'(bus.depth), 32'h2);
    check("n_epc",   bus.epc_out, 32'h80);
    check("n_isv",   32'(bus.in_service), 32'h5);
    do_mret();
    check("n_m1_epc", bus.epc_out, 32'h40);
    check("n_m1_isv", 32'(bus.in_service), 32'h1);
    do_mret();
    check("n_m2_depth", 32'(bus.depth), 32'h0);

    // No preemption by lower priority
    push_exp(32'h108, 2);
    pulse(3'b100);
    wait_req();
    ack(32'h200);
    pulse(3'b010);
    tick(3);
    check("np_pend", 32'(bus.pending), 32'h2);
    check("np_req",  32'(bus.irq_req), 32'h0);
    push_exp(32'h104, 2);
    do_mret();
    wait_req();
    ack(32'h300);
    check("np_isv", 32'(bus.in_service), 32'h2);
    do_mret();

    // Simultaneous edges on 0 and 1
    push_exp(32'h104, 2);
    pulse(3'b011);
    wait_req();
    ack(32'h44);
    tick(3);
    check("sim_req",  32'(bus.irq_req), 32'h0);
    check("sim_pend", 32'(bus.pending), 32'h1);
    push_exp(32'h100, 2);
    do_mret();
    wait_req();
    ack(32'h48);
    check("sim_isv", 32'(bus.in_service), 32'h1);
    check("sim_epc", bus.epc_out, 32'h48);
    do_mret();

    // mret with nothing in service
    do_mret();
    check("re_err",   32'(bus.ret_err), 32'h1);
    check("re_depth", 32'(bus.depth), 32'h0);
    check("re_isv",   32'(bus.in_service), 32'h0);
    check("re_req",   32'(bus.irq_req), 32'h0);

    // ack while IDLE is ignored
    ack(32'h123);
    check("ia_depth", 32'(bus.depth), 32'h0);
    check("ia_epc",   bus.epc_out, 32'h0);

    // ack + mret together in REQ
    push_exp(32'h100, 2);
    pulse(3'b001);
    wait_req();
    ack(32'h40);
    push_exp(32'h108, 2);
    pulse(3'b100);
    wait_req();
    bus.irq_ack = 1'b1;
    bus.mret    = 1'b1;
    bus.pc_next = 32'h99;
    tick(1);
    bus.irq_ack = 1'b0;
    bus.mret    = 1'b0;
    check("am_req",   32'(bus.irq_req), 32'h1);
    check("am_vec",   bus.irq_vec, 32'h108);
    check("am_depth", 32'(bus.depth), 32'h0);
    check("am_isv",   32'(bus.in_service), 32'h0);
    check("am_epc",   bus.epc_out, 32'h0);
    ack(32'h80);
    check("am_a_depth", 32'(bus.depth), 32'h1);
    check("am_a_isv",   32'(bus.in_service), 32'h4);
    check("am_a_epc",   bus.epc_out, 32'h80);
    do_mret();
    check("am_err_sticky", 32'(bus.ret_err), 32'h1);

    // Reset while a request is up
    push_exp(32'h104, 2);
    pulse(3'b010);
    wait_req();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rr_req",   32'(bus.irq_req), 32'h0);
    check("rr_vec",   bus.irq_vec, 32'h0);
    check("rr_pend",  32'(bus.pending), 32'h0);
    check("rr_isv",   32'(bus.in_service), 32'h0);
    check("rr_depth", 32'(bus.depth), 32'h0);
    check("rr_err",   32'(bus.ret_err), 32'h0);

`ifdef INTR_MASK_EN
    // Masked source latches pending but is not requested until unmasked
    bus.irq_mask = 3'b110;
    pulse(3'b001);
    tick(2);
    check("mk_pend", 32'(bus.pending), 32'h1);
    check("mk_req",  32'(bus.irq_req), 32'h0);
    push_exp(32'h100, 1);
    bus.irq_mask = 3'b111;
    tick(1);
    wait_req();
    ack(32'h60);
    do_mret();
`endif

    tick(3);
    check("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Multi-source vectored interrupt controller for the single-cycle RV32 core.
- Edge-detects external interrupt lines and latches them as pending.
- Arbitrates by fixed priority and allows nesting: only a strictly higher priority can preempt the source in service.
- Sequences entry and return with the core, raising a redirect request with a vector, saving return PCs on an internal stack, and supplying the EPC on mret.

Parameters:
NSRC, 3, number of interrupt sources; index NSRC-1 is highest priority
ADDR_W, 32, PC/vector width
VEC_BASE, 32'h0000_0100, vector of source 0
VEC_STRIDE, 4, byte distance between consecutive vectors

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
irq_in  in  NSRC  raw request lines, synchronous to clk, rising-edge sensitive
irq_ack  in  1  core accepts the request at an instruction boundary this cycle
pc_next  in  ADDR_W  return address, sampled when irq_ack=1
mret  in  1  one-cycle pulse, mret instruction retiring
irq_req  out  1  registered redirect request
irq_vec  out  ADDR_W  VEC_BASE + idx*VEC_STRIDE, stable while irq_req=1
epc_out  out  ADDR_W  top of the EPC stack (combinational); 0 when empty
pending  out  NSRC  latched pending bits
in_service  out  NSRC  sources currently being serviced
depth  out  $clog2(NSRC+1)  nesting depth
ret_err  out  1  sticky; mret seen with depth=0

Behaviour:
- Reset (rst=1 at clk edge):
  - irq_req, pending, in_service, depth, ret_err and irq_vec are all 0.
  - The edge-detect register is loaded with irq_in, so a line already high at reset does not fire.
  - Stack contents are don't-care.
  - Reset mid-request aborts the request. No ack is required.
- Edge detect:
  - pending[i] sets on irq_in[i] & ~irq_d[i].
  - A pending bit is cleared on ack of that source.
  - An edge in the same cycle as that clear keeps the bit set.
- Current priority cp = index of the highest set in_service bit, or -1 if none.
- Candidate = highest i with pending[i] and i > cp.
- FSM, 2 states:
  - IDLE:
    - If a candidate exists, the next cycle has irq_req=1 and irq_vec = vector(candidate); the winning index is latched. Go to REQ.
    - Request latency from the input edge is 2 cycles: 1 cycle edge->pending, then 1 cycle to irq_req.
  - REQ:
    - Hold irq_req and irq_vec with no re-arbitration, even if a higher priority source arrives.
    - On irq_ack=1 & mret=0:
      - push pc_next at stack[depth] and increment depth;
      - set in_service[idx] and clear pending[idx];
      - irq_req drops next cycle; go to IDLE.
    - Re-arbitration starts no earlier than the cycle after irq_req drops.
- mret:
  - Applies when depth>0, in either state.
  - Clears the highest in_service bit and decrements depth.
  - epc_out shows the new top from the next cycle.
  - If the new cp admits a waiting pending source, the normal IDLE request follows.
- mret with depth=0: ignored, and ret_err is set (sticky until rst).
- irq_ack and mret in the same cycle: the ack is ignored and irq_req stays asserted; mret is processed.
- irq_ack while in IDLE: ignored.
- Stack depth is NSRC entries. Overflow is impossible because nesting is strictly increasing in priority.
- Vector arithmetic is modulo 2^ADDR_W.

Optional Feature:
- Macro: INTR_MASK_EN.
- When defined:
  - Adds input irq_mask [NSRC-1:0], 1 = enabled.
  - Masked sources still latch pending but are excluded from candidate selection.
  - Unmasking a pending source makes it eligible the next cycle.
  - Masking a source while irq_req is already up for it does not withdraw the request.
- When undefined: no port, and all sources are enabled.

Test Plan:
- Single source: with NSRC=3, after reset pulse irq_in[0] -> irq_req=1 two cycles later with irq_vec=0x100. Ack with pc_next=0x40 -> depth=1, in_service=001, epc_out=0x40. mret -> depth=0, epc_out=0.
- Nesting: service source 0 (pc 0x40), then edge on irq_in[2] -> irq_req with vec 0x108. Ack pc 0x80 -> depth=2, epc_out=0x80. mret -> epc_out=0x40. mret -> depth 0.
- No preemption: in service of 2, edge on irq_in[1] -> pending=010, no irq_req. After mret -> irq_req with vec 0x104.
- Simultaneous edges on 0 and 1 -> request vec 0x104 first. After ack, no request, since 0 < cp. After mret -> vec 0x100.
- Boundaries:
  - mret with depth=0 -> ret_err=1 and state unchanged.
  - ack+mret together in REQ -> ack ignored, irq_req held.
  - rst asserted in REQ -> all outputs 0 the next cycle.
- INTR_MASK_EN: mask=110 with an edge on 0 -> pending=001 and no request. Set mask=111 -> irq_req the next cycle with vec 0x100.
